mem_alloc_arbiter: RTL and testbench
====================================

// Module: mem_alloc_arbiter
// PURPOSE
//  Shares the near-memory address space between NUM_REQ thread requesters.
//  - Round-robin arbitration of allocation requests.
//  - Next-fit slot allocation from an occupancy bitmap.
//  - Tracks frees and drives used_address / read_or_write / freed / freed_address
//    toward the memory controller.
//  - Sits between the thread scheduler and MemoryController.
// PARAMETERS
//  NUM_REQ    4    number of requesters (2..8)
//  ADDR_W     9    address width of used_address / freed_address
//  NUM_SLOTS  64   allocatable slots, addresses 0..NUM_SLOTS-1 (<= 2**ADDR_W)
// PORTS
//  clk            in   1          rising-edge clock
//  reset          in   1          asynchronous, active-high reset
//  req            in   NUM_REQ    per-requester allocation request (level)
//  req_rw         in   NUM_REQ    per-requester access type, 0=READ 1=WRITE
//  gnt            out  NUM_REQ    one-hot grant pulse, registered
//  gnt_valid      out  1          1 when any gnt bit is set
//  used_address   out  ADDR_W     slot allocated to the granted requester
//  read_or_write  out  1          req_rw of the granted requester
//  free_valid     in   1          free request strobe
//  free_addr      in   ADDR_W     slot to free
//  freed          out  1          pulse: a free was accepted
//  freed_address  out  ADDR_W     slot that was freed
//  free_err       out  1          pulse: free rejected (out of range or already free)
//  full           out  1          all NUM_SLOTS slots in use
//  used_count     out  ADDR_W+1   number of slots in use
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately, including mid-grant):
//   - bitmap all free; used_count=0; next_ptr=0; rr_last=NUM_REQ-1.
//   - All outputs 0, except full=0.
//  Arbitration (evaluated each cycle on pre-edge state):
//   - eligible[k] = req[k] & ~gnt[k]. A requester is masked in the cycle its own
//     gnt is high, so a held req yields at most one grant every 2 cycles.
//   - Winner = first eligible k searching rr_last+1, rr_last+2, ... mod NUM_REQ.
//  Slot search:
//   - Lowest free index s searching next_ptr .. NUM_SLOTS-1, then wrapping
//     0 .. next_ptr-1.
//  Alloc (any eligible requester and ~full), at the clock edge:
//   - gnt[k]<=1, gnt_valid<=1, used_address<=s, read_or_write<=req_rw[k].
//   - bitmap[s]<=1; rr_last<=k; next_ptr<=(s+1) mod NUM_SLOTS.
//   - Latency: req seen in cycle t -> gnt high in cycle t+1, for exactly 1 cycle.
//  No alloc in that cycle:
//   - gnt, gnt_valid <= 0.
//   - used_address and read_or_write hold their last value.
//  Free (free_valid), at the clock edge:
//   - Accepted if free_addr < NUM_SLOTS and bitmap[free_addr]==1:
//     bitmap[free_addr]<=0, freed<=1, freed_address<=free_addr.
//   - Otherwise: free_err<=1; bitmap and count unchanged; freed<=0.
//   - freed and free_err are 1-cycle pulses.
//  Simultaneous alloc and free in the same cycle:
//   - Both are applied.
//   - The search uses the pre-edge bitmap, so the freed slot is not reused
//     in that same cycle.
//   - used_count <= used_count + alloc - free_accepted.
//  Full:
//   - full = (used_count==NUM_SLOTS), combinational from the register.
//   - While full: no grants; req stays pending.
//   - Full with an accepted free in cycle t: the grant appears in cycle t+2.
//  Free of the slot granted in the same cycle: impossible, since that slot was
//   free pre-edge -> rejected with free_err.
// TESTING
//  1. Reset, req=4'b0001, req_rw[0]=1 held 4 cycles
//     -> gnt=0001 on cycles 2 and 4; used_address 0 then 1; read_or_write=1.
//  2. req=4'b1111 held
//     -> grant order 0,1,2,3,0 (rr_last starts at 3); addresses 0,1,2,3,4 consecutive.
//  3. Fill all 64 slots; full=1; req[2]=1 gets no gnt; free_addr=17 accepted
//     -> freed=1, freed_address=17; next cycle full=0; following cycle gnt[2],
//        used_address=17.
//  4. Error frees: free_addr=70 -> free_err=1. Free of an unallocated slot
//     -> free_err=1. used_count unchanged in both cases.
//  5. Same-cycle alloc + free of slot 5 (used_count=10, next_ptr=10)
//     -> used_address=10, freed_address=5, used_count stays 10.
//  6. Assert reset mid-grant with gnt high
//     -> gnt, gnt_valid, freed, used_count drop to 0 before the next clk edge;
//        first allocation after reset returns address 0.

Source files
------------

// File: rtl/mem_alloc_arbiter_if.sv
// Request/grant and free bus between the thread scheduler and
// the near-memory allocator.
interface mem_alloc_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_rw;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [ADDR_W-1:0]  used_address;
  logic               read_or_write;
  logic               free_valid;
  logic [ADDR_W-1:0]  free_addr;
  logic               freed;
  logic [ADDR_W-1:0]  freed_address;
  logic               free_err;
  logic               full;
  logic [ADDR_W:0]    used_count;

  modport master (
    output req, req_rw, free_valid, free_addr,
    input  gnt, gnt_valid, used_address, read_or_write,
    input  freed, freed_address, free_err, full, used_count
  );

  modport slave (
    input  req, req_rw, free_valid, free_addr,
    output gnt, gnt_valid, used_address, read_or_write,
    output freed, freed_address, free_err, full, used_count
  );
endinterface

// File: rtl/mem_alloc_arbiter.sv
// Round-robin requester arbitration with next-fit slot allocation
// from an occupancy bitmap, plus free tracking.
module mem_alloc_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 9,
  parameter int NUM_SLOTS = 64
) (
  input  logic              clk,
  input  logic              reset,
  mem_alloc_arbiter_if.slave bus
);
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = ADDR_W + 1;

  logic [NUM_SLOTS-1:0] bitmap_q, bitmap_d;
  logic [CW-1:0]        count_q, count_d;
  logic [SW-1:0]        next_ptr_q, next_ptr_d;
  logic [RW-1:0]        rr_last_q, rr_last_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic [ADDR_W-1:0]    used_addr_q, used_addr_d;
  logic                 rw_q, rw_d;
  logic                 freed_q, freed_d;
  logic [ADDR_W-1:0]    freed_addr_q, freed_addr_d;
  logic                 free_err_q, free_err_d;

  logic [NUM_REQ-1:0] elig;
  logic               win_found;
  logic [RW-1:0]      win_idx;
  logic [RW:0]        arb_k;
  logic               slot_found;
  logic [SW-1:0]      slot_idx;
  logic [SW:0]        srch_k;
  logic               full;
  logic               alloc;
  logic               free_in_range;
  logic               free_ok;

  assign full = (count_q == CW'(NUM_SLOTS));

  // A requester whose grant is currently high sits out this cycle.
  always_comb begin
    elig      = bus.req & ~gnt_q;
    win_found = 1'b0;
    win_idx   = '0;
    arb_k     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      arb_k = {1'b0, rr_last_q} + (RW+1)'(i);
      if (arb_k >= (RW+1)'(NUM_REQ))
        arb_k = arb_k - (RW+1)'(NUM_REQ);
      if (!win_found && elig[arb_k[RW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = arb_k[RW-1:0];
      end
    end
  end

  always_comb begin
    slot_found = 1'b0;
    slot_idx   = '0;
    srch_k     = '0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      srch_k = {1'b0, next_ptr_q} + (SW+1)'(j);
      if (srch_k >= (SW+1)'(NUM_SLOTS))
        srch_k = srch_k - (SW+1)'(NUM_SLOTS);
      if (!slot_found && !bitmap_q[srch_k[SW-1:0]]) begin
        slot_found = 1'b1;
        slot_idx   = srch_k[SW-1:0];
      end
    end
  end

  // Free validity is judged on the pre-edge bitmap, so a slot being
  // allocated this cycle can never be freed in the same cycle.
  assign free_in_range = ({1'b0, bus.free_addr} < CW'(NUM_SLOTS));
  assign free_ok = bus.free_valid && free_in_range &&
                   bitmap_q[bus.free_addr[SW-1:0]];
  assign alloc = win_found && !full && slot_found;

  always_comb begin
    bitmap_d     = bitmap_q;
    next_ptr_d   = next_ptr_q;
    rr_last_d    = rr_last_q;
    gnt_d        = '0;
    gnt_valid_d  = 1'b0;
    used_addr_d  = used_addr_q;
    rw_d         = rw_q;
    freed_d      = free_ok;
    freed_addr_d = freed_addr_q;
    free_err_d   = bus.free_valid && !free_ok;
    count_d      = count_q + CW'(alloc) - CW'(free_ok);
    if (free_ok) begin
      bitmap_d[bus.free_addr[SW-1:0]] = 1'b0;
      freed_addr_d = bus.free_addr;
    end
    if (alloc) begin
      bitmap_d[slot_idx] = 1'b1;
      gnt_d[win_idx]     = 1'b1;
      gnt_valid_d        = 1'b1;
      used_addr_d        = ADDR_W'(slot_idx);
      rw_d               = bus.req_rw[win_idx];
      rr_last_d          = win_idx;
      if (slot_idx == SW'(NUM_SLOTS - 1))
        next_ptr_d = '0;
      else
        next_ptr_d = slot_idx + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitmap_q     <= '0;
      count_q      <= '0;
      next_ptr_q   <= '0;
      rr_last_q    <= RW'(NUM_REQ - 1);
      gnt_q        <= '0;
      gnt_valid_q  <= 1'b0;
      used_addr_q  <= '0;
      rw_q         <= 1'b0;
      freed_q      <= 1'b0;
      freed_addr_q <= '0;
      free_err_q   <= 1'b0;
    end else begin
      bitmap_q     <= bitmap_d;
      count_q      <= count_d;
      next_ptr_q   <= next_ptr_d;
      rr_last_q    <= rr_last_d;
      gnt_q        <= gnt_d;
      gnt_valid_q  <= gnt_valid_d;
      used_addr_q  <= used_addr_d;
      rw_q         <= rw_d;
      freed_q      <= freed_d;
      freed_addr_q <= freed_addr_d;
      free_err_q   <= free_err_d;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.gnt_valid     = gnt_valid_q;
  assign bus.used_address  = used_addr_q;
  assign bus.read_or_write = rw_q;
  assign bus.freed         = freed_q;
  assign bus.freed_address = freed_addr_q;
  assign bus.free_err      = free_err_q;
  assign bus.full          = full;
  assign bus.used_count    = count_q;
endmodule

// File: tb/tb_mem_alloc_arbiter.sv
// Directed and random checks of mem_alloc_arbiter against a
// slot-array reference model.
module tb_mem_alloc_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_alloc_arbiter_if #(.NUM_REQ(4), .ADDR_W(9)) bus ();

  mem_alloc_arbiter #(
    .NUM_REQ(4), .ADDR_W(9), .NUM_SLOTS(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  bit m_used [64];
  int m_cnt, m_ptr, m_rr, m_gnt, m_ua, m_fa;
  bit m_gv, m_rw, m_freed, m_ferr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_used[i]) m_used[i] = 1'b0;
    m_cnt = 0; m_ptr = 0; m_rr = 3; m_gnt = 0; m_ua = 0; m_fa = 0;
    m_gv = 0; m_rw = 0; m_freed = 0; m_ferr = 0;
  endtask

  task automatic model_step();
    int win;
    int s;
    int fa;
    bit fok;
    win = -1;
    s = -1;
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (m_rr + i) % 4;
      if (win < 0 && bus.req[k] && !m_gnt[k]) win = k;
    end
    if (win >= 0 && m_cnt < 64)
      for (int j = 0; j < 64; j++) begin
        int idx;
        idx = (m_ptr + j) % 64;
        if (s < 0 && !m_used[idx]) s = idx;
      end
    fa = int'(bus.free_addr);
    fok = 1'b0;
    if (bus.free_valid && fa < 64)
      fok = m_used[fa];
    m_freed = fok;
    m_ferr = bus.free_valid && !fok;
    if (fok) begin
      m_used[fa] = 1'b0;
      m_fa = fa;
      m_cnt--;
    end
    if (s >= 0) begin
      m_used[s] = 1'b1;
      m_gnt = 1 << win;
      m_gv = 1;
      m_ua = s;
      m_rw = bus.req_rw[win];
      m_rr = win;
      m_ptr = (s + 1) % 64;
      m_cnt++;
    end else begin
      m_gnt = 0;
      m_gv = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(m_gnt));
    chk({tag, ".gv"}, 32'(bus.gnt_valid), 32'(m_gv));
    chk({tag, ".ua"}, 32'(bus.used_address), 32'(m_ua));
    chk({tag, ".rw"}, 32'(bus.read_or_write), 32'(m_rw));
    chk({tag, ".freed"}, 32'(bus.freed), 32'(m_freed));
    chk({tag, ".fa"}, 32'(bus.freed_address), 32'(m_fa));
    chk({tag, ".ferr"}, 32'(bus.free_err), 32'(m_ferr));
    chk({tag, ".full"}, 32'(bus.full), 32'(m_cnt == 64));
    chk({tag, ".cnt"}, 32'(bus.used_count), 32'(m_cnt));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.req_rw = '0;
    bus.free_valid = 1'b0;
    bus.free_addr = '0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    bus.req_rw = '0;
    bus.free_valid = 1'b0;
    bus.free_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    reset = 1'b0;

    // single held requester: one grant every other cycle
    bus.req = 4'b0001;
    bus.req_rw = 4'b0001;
    tick("t1a");
    chk("t1a_gnt", 32'(bus.gnt), 32'h1);
    chk("t1a_ua", 32'(bus.used_address), 32'd0);
    chk("t1a_rw", 32'(bus.read_or_write), 32'd1);
    tick("t1b");
    chk("t1b_gnt", 32'(bus.gnt), 32'h0);
    tick("t1c");
    chk("t1c_gnt", 32'(bus.gnt), 32'h1);
    chk("t1c_ua", 32'(bus.used_address), 32'd1);
    tick("t1d");

    // all requesters: rotating order, consecutive addresses
    do_reset();
    bus.req = 4'b1111;
    bus.req_rw = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      tick("t2");
      chk("t2_gnt", 32'(bus.gnt), 32'(1 << (i % 4)));
      chk("t2_ua", 32'(bus.used_address), 32'(i));
    end

    // fill, stall while full, free 17, grant reuses 17
    do_reset();
    bus.req = 4'b1111;
    repeat (64) tick("t3fill");
    chk("t3_full", 32'(bus.full), 32'd1);
    bus.req = 4'b0100;
    tick("t3s0");
    chk("t3s0_gnt", 32'(bus.gnt), 32'h0);
    tick("t3s1");
    chk("t3s1_gnt", 32'(bus.gnt), 32'h0);
    bus.free_valid = 1'b1;
    bus.free_addr = 9'd17;
    tick("t3f");
    chk("t3f_freed", 32'(bus.freed), 32'd1);
    chk("t3f_fa", 32'(bus.freed_address), 32'd17);
    chk("t3f_full", 32'(bus.full), 32'd0);
    bus.free_valid = 1'b0;
    tick("t3g");
    chk("t3g_gnt", 32'(bus.gnt), 32'h4);
    chk("t3g_ua", 32'(bus.used_address), 32'd17);

    // rejected frees leave the count alone
    bus.req = '0;
    bus.free_valid = 1'b1;
    bus.free_addr = 9'd70;
    tick("t4a");
    chk("t4a_ferr", 32'(bus.free_err), 32'd1);
    chk("t4a_cnt", 32'(bus.used_count), 32'd64);
    bus.free_addr = 9'd20;
    tick("t4b");
    bus.free_addr = 9'd20;
    tick("t4c");
    chk("t4c_ferr", 32'(bus.free_err), 32'd1);
    chk("t4c_cnt", 32'(bus.used_count), 32'd63);
    bus.free_valid = 1'b0;
    tick("t4d");

    // alloc and free in the same cycle
    do_reset();
    bus.req = 4'b1111;
    repeat (10) tick("t5fill");
    bus.req = 4'b0001;
    bus.free_valid = 1'b1;
    bus.free_addr = 9'd5;
    tick("t5");
    chk("t5_ua", 32'(bus.used_address), 32'd10);
    chk("t5_fa", 32'(bus.freed_address), 32'd5);
    chk("t5_cnt", 32'(bus.used_count), 32'd10);

    // async reset while grant and freed are high
    reset = 1'b1;
    #1;
    chk("t6_gnt", 32'(bus.gnt), 32'h0);
    chk("t6_gv", 32'(bus.gnt_valid), 32'd0);
    chk("t6_freed", 32'(bus.freed), 32'd0);
    chk("t6_cnt", 32'(bus.used_count), 32'd0);
    model_reset();
    bus.free_valid = 1'b0;
    bus.req = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.req = 4'b0001;
    tick("t6a");
    chk("t6a_ua", 32'(bus.used_address), 32'd0);
    chk("t6a_gnt", 32'(bus.gnt), 32'h1);

    // random traffic in phases of differing free pressure
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 300; c++) begin
        if (p == 1)
          bus.req = 4'($urandom);
        else
          bus.req = 4'($urandom & $urandom);
        bus.req_rw = 4'($urandom);
        bus.free_valid = ($urandom_range(0, 3) < (p + 1));
        if ($urandom_range(0, 9) == 0)
          bus.free_addr = 9'($urandom_range(64, 511));
        else
          bus.free_addr = 9'($urandom_range(0, 63));
        tick("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
